// File: rtl/branch_target_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : branch_target_buffer
//  Purpose  : Direct-mapped BTB with 2-bit saturating direction counters.
//             Combinational lookup at fetch, registered learning at execute,
//             mispredict detection, redirect PC and resolution statistics.
//  Revision : 1.0  initial release
// ============================================================================
module branch_target_buffer #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = 30 - IDX_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic        BranchValidE,
  input  logic        StallE,
  input  logic [31:0] PCE,
  input  logic        BranchE,
  input  logic [31:0] BranchTargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  output logic        MispredictE,
  output logic [31:0] RedirectPCE,
  output logic [31:0] BranchCount,
  output logic [31:0] MispredCount
);

  // Only the valid bits need reset; tag/target/ctr are ignored while invalid.
  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  logic [31:0]        target_mem [ENTRIES];
  logic [1:0]         ctr_mem    [ENTRIES];

  logic [IDX_W-1:0]   idx_f;
  logic [TAG_W-1:0]   tag_f;
  logic               hit_f;
  logic [IDX_W-1:0]   idx_e;
  logic [TAG_W-1:0]   tag_e;
  logic               hit_e;
  logic               upd;
  logic [1:0]         ctr_e;
  logic [1:0]         ctr_inc;
  logic [1:0]         ctr_dec;

  assign idx_f = PCF[IDX_W+1:2];
  assign tag_f = PCF[31:IDX_W+2];
  assign idx_e = PCE[IDX_W+1:2];
  assign tag_e = PCE[31:IDX_W+2];

  assign upd   = BranchValidE & ~StallE;

  // Fetch-side lookup; no bypass from a same-cycle update.
  assign hit_f       = valid[idx_f] && (tag_mem[idx_f] == tag_f);
  assign PredTakenF  = hit_f & ctr_mem[idx_f][1];
  assign PredTargetF = hit_f ? target_mem[idx_f] : (PCF + 32'd4);

  // Execute-side lookup used to decide between training and allocation.
  assign hit_e   = valid[idx_e] && (tag_mem[idx_e] == tag_e);
  assign ctr_e   = ctr_mem[idx_e];
  assign ctr_inc = (ctr_e == 2'b11) ? 2'b11 : (ctr_e + 2'd1);
  assign ctr_dec = (ctr_e == 2'b00) ? 2'b00 : (ctr_e - 2'd1);

  // Mispredict: wrong direction, or taken with a stale target.
  assign MispredictE = BranchValidE &
                       ((BranchE != PredTakenE) |
                        (BranchE & PredTakenE & (PredTargetE != BranchTargetE)));
  assign RedirectPCE = BranchE ? BranchTargetE : (PCE + 32'd4);

  // Valid bits: cleared by reset, set on a taken-branch allocation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (upd && !hit_e && BranchE) begin
      valid[idx_e] <= 1'b1;
    end
  end

  // Entry payload: train the counter on a hit, allocate on a taken miss.
  always_ff @(posedge clk) begin
    if (upd) begin
      if (hit_e) begin
        if (BranchE) begin
          ctr_mem[idx_e]    <= ctr_inc;
          target_mem[idx_e] <= BranchTargetE;
        end else begin
          ctr_mem[idx_e]    <= ctr_dec;
        end
      end else if (BranchE) begin
        tag_mem[idx_e]    <= tag_e;
        target_mem[idx_e] <= BranchTargetE;
        ctr_mem[idx_e]    <= 2'b10;
      end
    end
  end

  // Resolution statistics, counted once per unstalled branch; wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      BranchCount  <= '0;
      MispredCount <= '0;
    end else if (upd) begin
      BranchCount <= BranchCount + 32'd1;
      if (MispredictE) begin
        MispredCount <= MispredCount + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire
